// File: rtl/irq_controller_if.sv
// Core-side bus of the interrupt controller: request/acknowledge handshake
// plus the word-addressed configuration port from the data-memory decode.
interface irq_controller_if #(
   parameter int ID_W = 4
);
   logic            irq;
   logic [ID_W-1:0] irq_id;
   logic            ack;
   logic            rfe;
   logic            cfg_we;
   logic [2:0]      cfg_addr;
   logic [31:0]     cfg_wdata;
   logic [31:0]     cfg_rdata;

   modport master (
      input  irq, irq_id, cfg_rdata,
      output ack, rfe, cfg_we, cfg_addr, cfg_wdata
   );

   modport slave (
      output irq, irq_id, cfg_rdata,
      input  ack, rfe, cfg_we, cfg_addr, cfg_wdata
   );
endinterface

// File: rtl/irq_controller.sv
// Prioritised interrupt controller for the MIPS core: synchronises and latches
// sources, masks them, and presents one request at a time until RFE.
module irq_controller #(
   parameter int NSRC        = 8,
   parameter int SYNC_STAGES = 2,
   parameter int ID_W        = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NSRC-1:0]  src,
   irq_controller_if.slave  bus
);

   localparam logic [2:0] ADDR_PENDING = 3'd0;
   localparam logic [2:0] ADDR_MASK    = 3'd1;
   localparam logic [2:0] ADDR_EDGE    = 3'd2;
   localparam logic [2:0] ADDR_STATUS  = 3'd3;
   localparam logic [2:0] ADDR_RAW     = 3'd4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t          state;
   logic            irq_q;
   logic [ID_W-1:0] irq_id_q;

   logic [NSRC-1:0] sync_q [SYNC_STAGES];
   logic [NSRC-1:0] s;
   logic [NSRC-1:0] s_prev;

   logic [NSRC-1:0] pending_q;
   logic [NSRC-1:0] mask_q;
   logic [NSRC-1:0] edge_q;

   logic [NSRC-1:0] pending_set;
   logic [NSRC-1:0] pending_clr;
   logic [NSRC-1:0] pending_nxt;
   logic [NSRC-1:0] mask_nxt;
   logic [NSRC-1:0] id_onehot;
   logic [NSRC-1:0] req_vec;
   logic            win_valid;
   logic [ID_W-1:0] win_id;
   logic            req_hold;

   logic            wr_pending;
   logic            wr_mask;
   logic            wr_edge;
   logic            unused_wdata;

   assign s = sync_q[SYNC_STAGES-1];

   assign wr_pending = bus.cfg_we && (bus.cfg_addr == ADDR_PENDING);
   assign wr_mask    = bus.cfg_we && (bus.cfg_addr == ADDR_MASK);
   assign wr_edge    = bus.cfg_we && (bus.cfg_addr == ADDR_EDGE);

   assign unused_wdata = ^bus.cfg_wdata[31:NSRC];

   assign id_onehot = NSRC'(1) << irq_id_q;
   assign req_vec   = pending_q & mask_q;

   // Edge sources set on a 0->1 of the synchronised line, level sources every
   // cycle the line is high; a set always beats a same-cycle clear.
   always_comb begin
      pending_set = (s & ~s_prev & edge_q) | (s & ~edge_q);
      pending_clr = '0;
      if (wr_pending) begin
         pending_clr = bus.cfg_wdata[NSRC-1:0];
      end
      if ((state == REQ) && bus.ack && ((edge_q & id_onehot) != '0)) begin
         pending_clr = pending_clr | id_onehot;
      end
      pending_nxt = (pending_q & ~pending_clr) | pending_set;
      mask_nxt    = wr_mask ? bus.cfg_wdata[NSRC-1:0] : mask_q;
   end

   // The request is withdrawn in the same cycle its bit is cleared or masked,
   // so irq drops on the cycle right after the register write.
   assign req_hold = ((pending_nxt & mask_nxt & id_onehot) != '0);

   always_comb begin
      win_valid = 1'b0;
      win_id    = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (req_vec[i]) begin
            win_valid = 1'b1;
            win_id    = ID_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
         s_prev    <= '0;
         pending_q <= '0;
         mask_q    <= '0;
         edge_q    <= '1;
      end else begin
         sync_q[0] <= src;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
         s_prev    <= s;
         pending_q <= pending_nxt;
         mask_q    <= mask_nxt;
         if (wr_edge) begin
            edge_q <= bus.cfg_wdata[NSRC-1:0];
         end
      end
   end

   // irq_id is frozen once a request is presented; nothing preempts it until
   // the core either accepts it or its pending/mask bit goes away.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         irq_q    <= 1'b0;
         irq_id_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_valid) begin
                  irq_id_q <= win_id;
                  irq_q    <= 1'b1;
                  state    <= REQ;
               end
            end
            REQ: begin
               if (bus.ack) begin
                  irq_q <= 1'b0;
                  state <= SERVICE;
               end else if (!req_hold) begin
                  irq_q <= 1'b0;
                  state <= IDLE;
               end
            end
            SERVICE: begin
               irq_q <= 1'b0;
               if (bus.rfe) begin
                  state <= IDLE;
               end
            end
            default: begin
               irq_q <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      bus.cfg_rdata = '0;
      case (bus.cfg_addr)
         ADDR_PENDING: bus.cfg_rdata[NSRC-1:0] = pending_q;
         ADDR_MASK:    bus.cfg_rdata[NSRC-1:0] = mask_q;
         ADDR_EDGE:    bus.cfg_rdata[NSRC-1:0] = edge_q;
         ADDR_STATUS: begin
            bus.cfg_rdata[31]       = (state == SERVICE);
            bus.cfg_rdata[30]       = irq_q;
            bus.cfg_rdata[ID_W-1:0] = irq_id_q;
         end
         ADDR_RAW:     bus.cfg_rdata[NSRC-1:0] = s;
         default:      bus.cfg_rdata = '0;
      endcase
   end

   assign bus.irq    = irq_q;
   assign bus.irq_id = irq_id_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: each task drives one scenario and checks
// hand-computed register and handshake values.
module tb_irq_controller;

   localparam int NSRC = 8;
   localparam int ID_W = 4;

   logic            clk;
   logic            rst;
   logic [NSRC-1:0] src;
   int              checks;
   int              errors;
   logic [31:0]     rd;

   irq_controller_if #(.ID_W(ID_W)) bus ();

   irq_controller #(.NSRC(NSRC), .SYNC_STAGES(2), .ID_W(ID_W)) dut (
      .clk (clk),
      .rst (rst),
      .src (src),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = a;
      bus.cfg_wdata = d;
      tick(1);
      bus.cfg_we    = 1'b0;
      bus.cfg_wdata = '0;
   endtask

   task automatic cfg_read(input logic [2:0] a, output logic [31:0] d);
      bus.cfg_addr = a;
      #1;
      d = bus.cfg_rdata;
   endtask

   task automatic pulse_ack();
      bus.ack = 1'b1;
      tick(1);
      bus.ack = 1'b0;
   endtask

   task automatic pulse_rfe();
      bus.rfe = 1'b1;
      tick(1);
      bus.rfe = 1'b0;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      src           = '0;
      bus.ack       = 1'b0;
      bus.rfe       = 1'b0;
      bus.cfg_we    = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_wdata = '0;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (bus.irq !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_irq: got %b expected 0", bus.irq);
      end
      checks++;
      if (bus.irq_id !== 4'd0) begin
         errors++; $display("[TB] FAIL reset_irq_id: got %0d expected 0", bus.irq_id);
      end
      cfg_read(3'd0, rd); checks++;
      if (rd !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_pending: got %h expected 00000000", rd);
      end
      cfg_read(3'd1, rd); checks++;
      if (rd !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_mask: got %h expected 00000000", rd);
      end
      cfg_read(3'd2, rd); checks++;
      if (rd !== 32'h0000_00FF) begin
         errors++; $display("[TB] FAIL reset_edge: got %h expected 000000ff", rd);
      end
      cfg_read(3'd3, rd); checks++;
      if (rd !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_status: got %h expected 00000000", rd);
      end
      cfg_write(3'd5, 32'hFFFF_FFFF);
      cfg_read(3'd5, rd); checks++;
      if (rd !== 32'h0) begin
         errors++; $display("[TB] FAIL unused_addr: got %h expected 00000000", rd);
      end
      cfg_write(3'd1, 32'hFFFF_FF5A);
      cfg_read(3'd1, rd); checks++;
      if (rd !== 32'h0000_005A) begin
         errors++; $display("[TB] FAIL mask_upper_bits: got %h expected 0000005a", rd);
      end
   endtask

   task automatic test_single_edge();
      do_reset();
      cfg_write(3'd1, 32'h01);
      cfg_write(3'd2, 32'h01);
      src = 8'h01;
      tick(1);
      src = 8'h00;
      tick(1);
      cfg_read(3'd4, rd); checks++;
      if (rd !== 32'h01) begin
         errors++; $display("[TB] FAIL raw_sync: got %h expected 00000001", rd);
      end
      tick(1);
      cfg_read(3'd0, rd); checks++;
      if (rd !== 32'h01 || bus.irq !== 1'b0) begin
         errors++; $display("[TB] FAIL edge_latency: got pending %h irq %b expected 00000001 irq 0", rd, bus.irq);
      end
      tick(1);
      checks++;
      if (bus.irq !== 1'b1 || bus.irq_id !== 4'd0) begin
         errors++; $display("[TB] FAIL req_latency: got irq %b id %0d expected irq 1 id 0", bus.irq, bus.irq_id);
      end
      pulse_ack();
      cfg_read(3'd0, rd); checks++;
      if (bus.irq !== 1'b0 || rd !== 32'h0) begin
         errors++; $display("[TB] FAIL ack_clear: got irq %b pending %h expected irq 0 pending 00000000", bus.irq, rd);
      end
      pulse_rfe();
      tick(3);
      cfg_read(3'd3, rd); checks++;
      if (bus.irq !== 1'b0 || rd !== 32'h0) begin
         errors++; $display("[TB] FAIL after_rfe: got irq %b status %h expected irq 0 status 00000000", bus.irq, rd);
      end
      pulse_ack();
      cfg_read(3'd3, rd); checks++;
      if (rd !== 32'h0) begin
         errors++; $display("[TB] FAIL ack_in_idle: got status %h expected 00000000", rd);
      end
   endtask

   task automatic test_priority();
      do_reset();
      cfg_write(3'd1, 32'hFF);
      src = 8'h24;
      tick(4);
      checks++;
      if (bus.irq !== 1'b1 || bus.irq_id !== 4'd2) begin
         errors++; $display("[TB] FAIL priority_first: got irq %b id %0d expected irq 1 id 2", bus.irq, bus.irq_id);
      end
      pulse_ack();
      cfg_read(3'd0, rd); checks++;
      if (rd !== 32'h20) begin
         errors++; $display("[TB] FAIL priority_pending: got %h expected 00000020", rd);
      end
      pulse_rfe();
      checks++;
      if (bus.irq !== 1'b0) begin
         errors++; $display("[TB] FAIL rfe_gap: got irq %b expected 0", bus.irq);
      end
      tick(1);
      checks++;
      if (bus.irq !== 1'b1 || bus.irq_id !== 4'd5) begin
         errors++; $display("[TB] FAIL priority_second: got irq %b id %0d expected irq 1 id 5", bus.irq, bus.irq_id);
      end
   endtask

   task automatic test_level();
      do_reset();
      cfg_write(3'd2, 32'h00);
      cfg_write(3'd1, 32'h08);
      src = 8'h08;
      tick(4);
      checks++;
      if (bus.irq !== 1'b1 || bus.irq_id !== 4'd3) begin
         errors++; $display("[TB] FAIL level_req: got irq %b id %0d expected irq 1 id 3", bus.irq, bus.irq_id);
      end
      pulse_ack();
      cfg_read(3'd0, rd); checks++;
      if (rd !== 32'h08) begin
         errors++; $display("[TB] FAIL level_hold: got %h expected 00000008", rd);
      end
      cfg_read(3'd3, rd); checks++;
      if (rd !== 32'h8000_0003) begin
         errors++; $display("[TB] FAIL level_status: got %h expected 80000003", rd);
      end
      src = 8'h00;
      tick(3);
      cfg_write(3'd0, 32'h08);
      pulse_rfe();
      tick(3);
      cfg_read(3'd0, rd); checks++;
      if (bus.irq !== 1'b0 || rd !== 32'h0) begin
         errors++; $display("[TB] FAIL level_cleared: got irq %b pending %h expected irq 0 pending 00000000", bus.irq, rd);
      end
   endtask

   task automatic test_withdraw();
      do_reset();
      cfg_write(3'd1, 32'h02);
      src = 8'h02;
      tick(4);
      checks++;
      if (bus.irq !== 1'b1 || bus.irq_id !== 4'd1) begin
         errors++; $display("[TB] FAIL withdraw_req: got irq %b id %0d expected irq 1 id 1", bus.irq, bus.irq_id);
      end
      cfg_write(3'd1, 32'h00);
      cfg_read(3'd3, rd); checks++;
      if (bus.irq !== 1'b0 || rd !== 32'h0000_0001) begin
         errors++; $display("[TB] FAIL withdraw: got irq %b status %h expected irq 0 status 00000001", bus.irq, rd);
      end
      cfg_read(3'd0, rd); checks++;
      if (rd !== 32'h02) begin
         errors++; $display("[TB] FAIL withdraw_pending: got %h expected 00000002", rd);
      end
      cfg_write(3'd1, 32'h02);
      tick(1);
      checks++;
      if (bus.irq !== 1'b1 || bus.irq_id !== 4'd1) begin
         errors++; $display("[TB] FAIL withdraw_restore: got irq %b id %0d expected irq 1 id 1", bus.irq, bus.irq_id);
      end
   endtask

   task automatic test_set_wins();
      do_reset();
      src = 8'h10;
      tick(2);
      cfg_write(3'd0, 32'h10);
      cfg_read(3'd0, rd); checks++;
      if (rd !== 32'h10) begin
         errors++; $display("[TB] FAIL set_wins: got %h expected 00000010", rd);
      end
      cfg_write(3'd0, 32'h10);
      cfg_read(3'd0, rd); checks++;
      if (rd !== 32'h0) begin
         errors++; $display("[TB] FAIL w1c: got %h expected 00000000", rd);
      end
   endtask

   task automatic test_reset_in_service();
      do_reset();
      cfg_write(3'd2, 32'h00);
      cfg_write(3'd1, 32'h02);
      src = 8'h06;
      tick(4);
      pulse_ack();
      cfg_read(3'd0, rd); checks++;
      if (rd !== 32'h06) begin
         errors++; $display("[TB] FAIL service_pending: got %h expected 00000006", rd);
      end
      cfg_read(3'd3, rd); checks++;
      if (rd !== 32'h8000_0001) begin
         errors++; $display("[TB] FAIL service_status: got %h expected 80000001", rd);
      end
      src = 8'h00;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      cfg_read(3'd0, rd); checks++;
      if (rd !== 32'h0) begin
         errors++; $display("[TB] FAIL midreset_pending: got %h expected 00000000", rd);
      end
      cfg_read(3'd1, rd); checks++;
      if (rd !== 32'h0) begin
         errors++; $display("[TB] FAIL midreset_mask: got %h expected 00000000", rd);
      end
      cfg_read(3'd3, rd); checks++;
      if (rd !== 32'h0 || bus.irq !== 1'b0) begin
         errors++; $display("[TB] FAIL midreset_status: got %h irq %b expected 00000000 irq 0", rd, bus.irq);
      end
      pulse_rfe();
      tick(2);
      cfg_read(3'd3, rd); checks++;
      if (rd !== 32'h0 || bus.irq !== 1'b0) begin
         errors++; $display("[TB] FAIL rfe_after_reset: got %h irq %b expected 00000000 irq 0", rd, bus.irq);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single_edge();
      test_priority();
      test_level();
      test_withdraw();
      test_set_wins();
      test_reset_in_service();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
